ysyx_22040895_ifu: RTL and testbench

YSYX_22040895_IFU -- requirements
Module: ysyx_22040895_ifu

---
 rtl/ysyx_22040895_ifu_pkg.sv | 20 ++
 rtl/ysyx_22040895_pc_reg.sv | 30 +++
 rtl/ysyx_22040895_ifu.sv | 101 ++++++++++
 tb/tb_ysyx_22040895_ifu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared widths, FSM encoding and reset address for the instruction fetch unit.
package ysyx_22040895_ifu_pkg;

  localparam int REG_BUS  = 64;
  localparam int INST_BUS = 32;

  localparam logic [REG_BUS-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  // Fetch addresses are always word aligned.
  function automatic logic [REG_BUS-1:0] align_pc(input logic [REG_BUS-1:0] addr);
    return {addr[REG_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22040895_pc_reg.sv
// Fetch pc register: reset value, redirect target, or sequential pc+4.
module ysyx_22040895_pc_reg
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [REG_BUS-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [REG_BUS-1:0] dnpc,
  input  logic               advance,
  output logic [REG_BUS-1:0] pc
);

  logic [REG_BUS-1:0] pc_reg;

  // Redirect outranks the sequential step; pc+4 simply wraps at 2^64.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (redirect) begin
      pc_reg <= align_pc(dnpc);
    end else if (advance) begin
      pc_reg <= pc_reg + 64'd4;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: one outstanding memory request, single-entry output buffer.
module ysyx_22040895_ifu
  import ysyx_22040895_ifu_pkg::*;
#(
  parameter logic [REG_BUS-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_branch_i_ifu,
  input  logic [REG_BUS-1:0]  dnpc_i_ifu,
  output logic                imem_req_valid_o_ifu,
  input  logic                imem_req_ready_i_ifu,
  output logic [REG_BUS-1:0]  imem_addr_o_ifu,
  input  logic                imem_rsp_valid_i_ifu,
  input  logic [INST_BUS-1:0] imem_rsp_data_i_ifu,
  output logic                inst_valid_o_ifu,
  input  logic                inst_ready_i_ifu,
  output logic [INST_BUS-1:0] inst_o_ifu,
  output logic [REG_BUS-1:0]  pc_o_ifu
);

  ifu_state_e          state_reg, state_next;
  logic                kill_reg, kill_next;
  logic [INST_BUS-1:0] inst_reg;
  logic [REG_BUS-1:0]  pc_o_reg;
  logic [REG_BUS-1:0]  pc;
  logic                capture;
  logic                advance;

  ysyx_22040895_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .redirect (jump_branch_i_ifu),
    .dnpc     (dnpc_i_ifu),
    .advance  (advance),
    .pc       (pc)
  );

  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    capture    = 1'b0;
    advance    = 1'b0;
    unique case (state_reg)
      S_REQ: begin
        if (imem_req_ready_i_ifu) begin
          state_next = S_WAIT;
          // A redirect in the accept cycle makes the in-flight word stale.
          kill_next  = jump_branch_i_ifu;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i_ifu) begin
          kill_next = 1'b0;
          if (jump_branch_i_ifu || kill_reg) begin
            state_next = S_REQ;
          end else begin
            state_next = S_HOLD;
            capture    = 1'b1;
          end
        end else if (jump_branch_i_ifu) begin
          kill_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (jump_branch_i_ifu) begin
          state_next = S_REQ;
        end else if (inst_ready_i_ifu) begin
          state_next = S_REQ;
          advance    = 1'b1;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_REQ;
      kill_reg  <= 1'b0;
      inst_reg  <= '0;
      pc_o_reg  <= '0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
      if (capture) begin
        inst_reg <= imem_rsp_data_i_ifu;
        pc_o_reg <= pc;
      end
    end
  end

  assign imem_req_valid_o_ifu = (state_reg == S_REQ);
  assign imem_addr_o_ifu      = pc;
  assign inst_valid_o_ifu     = (state_reg == S_HOLD);
  assign inst_o_ifu           = inst_reg;
  assign pc_o_ifu             = pc_o_reg;

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Directed scenario tasks plus a randomized run checked against an architectural pc/memory model.
module tb_ysyx_22040895_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jb;
  logic [63:0] dnpc;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc_o;

  int checks = 0;
  int errors = 0;

  ysyx_22040895_ifu #(.RESET_PC(RST_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .jump_branch_i_ifu    (jb),
    .dnpc_i_ifu           (dnpc),
    .imem_req_valid_o_ifu (req_valid),
    .imem_req_ready_i_ifu (req_ready),
    .imem_addr_o_ifu      (addr),
    .imem_rsp_valid_i_ifu (rsp_valid),
    .imem_rsp_data_i_ifu  (rsp_data),
    .inst_valid_o_ifu     (inst_valid),
    .inst_ready_i_ifu     (inst_ready),
    .inst_o_ifu           (inst),
    .pc_o_ifu             (pc_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[63:32] ^ a[31:0]) * 32'h9E37_79B1 ^ 32'h0000_0013;
  endfunction

  // Drive one request/response pair with a no-stall memory; leaves the DUT holding the word.
  task automatic fetch_one(input logic [31:0] data);
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = data;
    tick;
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; jb = 1'b0; dnpc = '0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; inst_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid: got %b want 1", req_valid); end
    checks++; if (addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", addr, RST_PC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    checks++; if (pc_o !== 64'h0) begin errors++; $display("FAIL reset_pc_o: got %h want 0", pc_o); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    req_ready = 1'b1;
    checks++; if (addr !== 64'h8000_0000 || req_valid !== 1'b1) begin errors++; $display("FAIL basic_req: got v=%b a=%h want v=1 a=80000000", req_valid, addr); end
    tick;
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0413;
    checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait: got rv=%b iv=%b want 0/0", req_valid, inst_valid); end
    tick;
    rsp_valid = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || pc_o !== 64'h8000_0000) begin errors++; $display("FAIL basic_deliver: got v=%b i=%h pc=%h want 1/00000413/80000000", inst_valid, inst, pc_o); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_exclusive: req_valid=%b with inst_valid", req_valid); end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    checks++; if (req_valid !== 1'b1 || addr !== 64'h8000_0004 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_next: got v=%b a=%h iv=%b want 1/80000004/0", req_valid, addr, inst_valid); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure;
    fetch_one(32'hAAAA_0001);
    for (int i = 0; i < 5; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== 32'hAAAA_0001 || pc_o !== 64'h8000_0004 || req_valid !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got iv=%b i=%h pc=%h rv=%b want 1/aaaa0001/80000004/0", i, inst_valid, inst, pc_o, req_valid);
      end
      tick;
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    checks++; if (req_valid !== 1'b1 || addr !== 64'h8000_0008) begin errors++; $display("FAIL bp_next: got v=%b a=%h want 1/80000008", req_valid, addr); end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_accept;
    req_ready = 1'b1; jb = 1'b1; dnpc = 64'h8000_0102;
    tick;
    req_ready = 1'b0; jb = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_0001;
    tick;
    rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_valid !== 1'b0 || req_valid !== 1'b1 || addr !== 64'h8000_0100) begin
        errors++; $display("FAIL redir_accept%0d: got iv=%b rv=%b a=%h want 0/1/80000100", i, inst_valid, req_valid, addr);
      end
      tick;
    end
    $display("test_redirect_accept done");
  endtask

  task automatic test_redirect_hold;
    int delivered;
    delivered = 0;
    fetch_one(32'h1111_0001);
    checks++; if (inst_valid !== 1'b1 || pc_o !== 64'h8000_0100) begin errors++; $display("FAIL redir_hold_pre: got iv=%b pc=%h want 1/80000100", inst_valid, pc_o); end
    inst_ready = 1'b1; jb = 1'b1; dnpc = 64'h8000_0200;
    if (inst_valid) delivered++;
    tick;
    inst_ready = 1'b0; jb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (inst_valid) delivered++;
      tick;
    end
    checks++; if (delivered !== 1) begin errors++; $display("FAIL redir_hold_count: got %0d deliveries want 1", delivered); end
    checks++; if (req_valid !== 1'b1 || addr !== 64'h8000_0200) begin errors++; $display("FAIL redir_hold_addr: got v=%b a=%h want 1/80000200", req_valid, addr); end
    $display("test_redirect_hold done");
  endtask

  task automatic test_req_stall;
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_valid !== 1'b1 || addr !== 64'h8000_0200) begin errors++; $display("FAIL stall%0d: got v=%b a=%h want 1/80000200", i, req_valid, addr); end
      tick;
    end
    jb = 1'b1; dnpc = 64'h8000_0301;
    tick;
    jb = 1'b0;
    checks++; if (req_valid !== 1'b1 || addr !== 64'h8000_0300) begin errors++; $display("FAIL stall_redir: got v=%b a=%h want 1/80000300", req_valid, addr); end
    fetch_one(32'h5555_0001);
    checks++; if (inst_valid !== 1'b1 || pc_o !== 64'h8000_0300 || inst !== 32'h5555_0001) begin errors++; $display("FAIL stall_deliver: got iv=%b pc=%h i=%h want 1/80000300/55550001", inst_valid, pc_o, inst); end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    $display("test_req_stall done");
  endtask

  task automatic test_wrap;
    jb = 1'b1; dnpc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    jb = 1'b0;
    checks++; if (addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffffffffffc", addr); end
    fetch_one(32'h3333_0001);
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    checks++; if (req_valid !== 1'b1 || addr !== 64'h0) begin errors++; $display("FAIL wrap_next: got v=%b a=%h want 1/0", req_valid, addr); end
    $display("test_wrap done");
  endtask

  task automatic test_reset_midwait;
    req_ready = 1'b1;
    tick;
    req_ready = 1'b0;
    rst = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hBAD0_0001;
    tick;
    rst = 1'b0;
    tick;
    rsp_valid = 1'b0;
    checks++; if (req_valid !== 1'b1 || addr !== RST_PC || inst_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_ignore: got rv=%b a=%h iv=%b want 1/80000000/0", req_valid, addr, inst_valid); end
    fetch_one(32'h2222_0001);
    checks++; if (inst_valid !== 1'b1 || pc_o !== RST_PC || inst !== 32'h2222_0001) begin errors++; $display("FAIL rst_wait_restart: got iv=%b pc=%h i=%h want 1/80000000/22220001", inst_valid, pc_o, inst); end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    $display("test_reset_midwait done");
  endtask

  // The model only knows the architectural next-fetch pc and a one-deep memory pipe.
  task automatic test_random;
    logic [63:0] exp_pc;
    logic [63:0] mem_addr;
    bit          mem_pend;
    int          mem_wait;
    int          delivered;
    int          bad;
    rst = 1'b1; jb = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; inst_ready = 1'b0;
    tick;
    rst = 1'b0;
    exp_pc = RST_PC; mem_pend = 1'b0; mem_addr = '0; mem_wait = 0; delivered = 0; bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if (req_valid && inst_valid) begin
        errors++; bad++; $display("FAIL rand_exclusive cyc%0d: both valids high", cyc);
      end else if (req_valid && addr !== exp_pc) begin
        errors++; bad++; $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, addr, exp_pc);
      end else if (inst_valid && (pc_o !== exp_pc || inst !== mem_word(exp_pc))) begin
        errors++; bad++; $display("FAIL rand_inst cyc%0d: got pc=%h i=%h want pc=%h i=%h", cyc, pc_o, inst, exp_pc, mem_word(exp_pc));
      end
      if (bad > 10) break;
      req_ready  = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      jb         = ($urandom_range(0, 9) == 0);
      dnpc       = {$urandom, $urandom};
      rsp_valid  = mem_pend && (mem_wait == 0);
      rsp_data   = rsp_valid ? mem_word(mem_addr) : $urandom;
      if (rsp_valid) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (req_valid && req_ready) begin
        mem_pend = 1'b1; mem_addr = addr; mem_wait = $urandom_range(0, 3);
      end
      if (inst_valid && inst_ready) delivered++;
      if (jb) exp_pc = {dnpc[63:2], 2'b00};
      else if (inst_valid && inst_ready) exp_pc = exp_pc + 64'd4;
      tick;
    end
    jb = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; inst_ready = 1'b0;
    checks++; if (delivered < 50) begin errors++; $display("FAIL rand_progress: got %0d deliveries want >= 50", delivered); end
    $display("test_random done: %0d instructions delivered", delivered);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_redirect_accept;
    test_redirect_hold;
    test_req_stall;
    test_wrap;
    test_reset_midwait;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
